dmi_jtag_host: RTL and testbench
================================

Name: dmi_jtag_host

Overview:
- JTAG initiator that drives a dmi_jtag_tap-style responder from a system clock.
- Generates TCK/TMS/TDI and samples TDO to run TAP reset, IR scan, DR scan and idle sequences on command.
- Returns the captured TDO bits through a valid/ready response channel.
- Used by on-chip test/boot logic and by the verification environment to access the DTMCS and DMI registers without an external probe.

Parameters:
- IrLength, 5, instruction register length in bits (1..16).
- ClkDivWidth, 8, width of the TCK divider input.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active high
- clk_div_i  in  ClkDivWidth  TCK half-period minus 1, in clk_i cycles; sampled at command accept and at reset release
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_op_i  in  2  0=TAP_RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE
- cmd_len_i  in  6  DR bit count or IDLE TCK count; 0 encodes 64; ignored for IR_SCAN and TAP_RESET
- cmd_data_i  in  64  TDI data, shifted LSB first
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_data_o  out  64  captured TDO, right-justified, bit i = i-th shifted bit
- busy_o  out  1  sequence in progress
- tck_o  out  1  JTAG test clock
- tms_o  out  1  JTAG mode select
- tdi_o  out  1  JTAG data to target
- trst_no  out  1  JTAG test reset, active low
- td_i  in  1  TDO from target

Behaviour:
- Reset values:
  - tck_o=0, tms_o=1, tdi_o=0, trst_no=0, cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=1.
  - All outputs are registered.
- trst_no rises 1 cycle after rst_i deasserts.
- After reset release, the block automatically runs the TAP_RESET sequence. The command port stays not-ready until that sequence finishes. No response is produced for this automatic sequence.
- TCK timing:
  - Each TCK cycle is a low phase of D+1 clk_i cycles followed by a high phase of D+1 clk_i cycles, where D is the latched clk_div_i.
  - tms_o and tdi_o update on the first clk_i cycle of the low phase.
  - td_i is sampled on the clk_i cycle where tck_o goes 0->1.
  - tck_o is held low between commands.
- Handshake:
  - cmd_ready_o = FSM in IDLE and rsp_valid_o low.
  - A command is accepted when cmd_valid_i and cmd_ready_o are both high.
  - The first TCK low phase starts on the next cycle.
  - rsp_valid_o asserts on the cycle after the last TCK high phase ends, and holds with stable data until rsp_ready_i. It clears in the cycle after acceptance.
  - Every accepted command produces exactly one response.
- FSM states: IDLE, PRE, SHIFT, POST, RESP. The TAP is assumed to be in RunTestIdle between commands.
- TMS sequences per TCK, starting from RunTestIdle:
  - TAP_RESET: 1,1,1,1,1,0 (6 TCKs); rsp_data_o=0.
  - IR_SCAN:
    - PRE 1,1,0,0.
    - SHIFT IrLength bits at TMS=0, except TMS=1 on the last bit.
    - POST 1,0.
    - Total IrLength+6 TCKs.
  - DR_SCAN:
    - PRE 1,0,0.
    - SHIFT N bits with the last bit at TMS=1.
    - POST 1,0.
    - Total N+5 TCKs.
  - IDLE: N TCKs at TMS=0; rsp_data_o=0.
- Shift data:
  - tdi_o = cmd_data_i[k] during the k-th SHIFT TCK.
  - td_i sampled at the k-th SHIFT rising edge goes into rsp_data_o[k].
  - Bits at and above N (or IrLength) are 0.
  - tdi_o=0 outside SHIFT.
- A bit counter counts down to 0 and wraps to the next phase; the 64-bit case (cmd_len_i=0) needs no special path.
- Changes to clk_div_i mid-command are ignored.
- rst_i mid-operation:
  - Aborts the sequence and discards any pending response.
  - Outputs take reset values on the next cycle.
  - The automatic TAP_RESET sequence reruns after release.
- Commands presented while not ready are ignored. The input is not latched.

Test Plan:
- Reset release, clk_div_i=0 -> trst_no=1 one cycle later; 6 TCKs, each 2 clk_i, with TMS 1,1,1,1,1,0; cmd_ready_o=1 afterwards; rsp_valid_o stays 0.
- IR_SCAN, data 0x01, against a dmi_jtag_tap model -> 11 TCKs; TMS 1,1,0,0,0,0,0,0,1,1,0; TDI shift bits 1,0,0,0,0; rsp_data_o=0x05 (capture pattern).
- DR_SCAN, len 32, IDCODE selected, IdcodeValue=0x00000001 -> 37 TCKs; rsp_data_o=0x0000_0000_0000_0001.
- IR_SCAN 0x1F, then DR_SCAN len 8 with data 0xA5 -> rsp_data_o=0x4A (one-bit bypass delay); DR_SCAN with len 0 -> 69 TCKs and a full 64-bit capture.
- clk_div_i=3, rsp_ready_i held low for 20 cycles after response -> TCK period 8 clk_i; rsp_valid_o and data stable; cmd_ready_o=0 until acceptance, then 1 one cycle later.
- rst_i pulsed during the SHIFT of a DR_SCAN -> next cycle tck_o=0, tms_o=1, rsp_valid_o=0, busy_o=1; automatic 6-TCK reset follows; the model TAP ends in RunTestIdle with IR=IDCODE.

Source files
------------

// File: rtl/dmi_jtag_host.sv
// JTAG initiator: runs TAP reset, IR/DR scans and idle cycles on command and
// returns the captured TDO bits over a valid/ready response channel.
`timescale 1ns/1ps
module dmi_jtag_host #(
  parameter int unsigned IrLength    = 5,
  parameter int unsigned ClkDivWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ClkDivWidth-1:0] clk_div_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_op_i,
  input  logic [5:0]             cmd_len_i,
  input  logic [63:0]            cmd_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [63:0]            rsp_data_o,
  output logic                   busy_o,
  output logic                   tck_o,
  output logic                   tms_o,
  output logic                   tdi_o,
  output logic                   trst_no,
  input  logic                   td_i
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP} state_e;
  typedef enum logic [1:0] {OP_TAP_RESET, OP_IR_SCAN, OP_DR_SCAN, OP_IDLE} op_e;

  localparam logic [5:0] IrLenM1 = 6'(IrLength - 1);

  state_e                 state;
  logic [ClkDivWidth-1:0] div_q, div_cnt;
  logic [5:0]             cnt, shift_len_m1, bit_idx, pre_tms;
  logic                   has_shift, auto_seq;
  logic [63:0]            data_q, cap_q;

  op_e        start_op;
  logic       start, seq_done, st_shift;
  logic [5:0] st_pre_tms, st_cnt, st_len_m1;

  // PRE carries a LSB-first TMS pattern; IDLE commands reuse it with all zeros
  always_comb begin
    start      = (state == S_IDLE) && (!trst_no || (cmd_valid_i && cmd_ready_o));
    start_op   = trst_no ? op_e'(cmd_op_i) : OP_TAP_RESET;
    st_pre_tms = '0;
    st_cnt     = cmd_len_i - 6'd1;
    st_shift   = 1'b0;
    st_len_m1  = cmd_len_i - 6'd1;
    case (start_op)
      OP_TAP_RESET: begin st_pre_tms = 6'b011111; st_cnt = 6'd5; end
      OP_IR_SCAN:   begin st_pre_tms = 6'b000011; st_cnt = 6'd3; st_shift = 1'b1; st_len_m1 = IrLenM1; end
      OP_DR_SCAN:   begin st_pre_tms = 6'b000001; st_cnt = 6'd2; st_shift = 1'b1; end
      default:      ;
    endcase
    seq_done = tck_o && (div_cnt == '0) && (cnt == '0) &&
               ((state == S_PRE && !has_shift) || state == S_POST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      div_q        <= '0;
      div_cnt      <= '0;
      cnt          <= '0;
      shift_len_m1 <= '0;
      bit_idx      <= '0;
      pre_tms      <= '0;
      has_shift    <= 1'b0;
      auto_seq     <= 1'b0;
      data_q       <= '0;
      cap_q        <= '0;
      tck_o        <= 1'b0;
      tms_o        <= 1'b1;
      tdi_o        <= 1'b0;
      trst_no      <= 1'b0;
      cmd_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      busy_o       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          trst_no      <= 1'b1;
          auto_seq     <= !trst_no;
          cmd_ready_o  <= 1'b0;
          busy_o       <= 1'b1;
          div_q        <= clk_div_i;
          div_cnt      <= clk_div_i;
          tck_o        <= 1'b0;
          tms_o        <= st_pre_tms[0];
          tdi_o        <= 1'b0;
          pre_tms      <= st_pre_tms;
          cnt          <= st_cnt;
          has_shift    <= st_shift;
          shift_len_m1 <= st_len_m1;
          data_q       <= cmd_data_i;
          cap_q        <= '0;
          bit_idx      <= '0;
          state        <= S_PRE;
        end
        S_RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - ClkDivWidth'(1);
          end else begin
            div_cnt <= div_q;
            tck_o   <= ~tck_o;
            if (!tck_o) begin
              if (state == S_SHIFT) cap_q[bit_idx] <= td_i;
            end else if (seq_done) begin
              busy_o <= 1'b0;
              if (auto_seq) begin
                cmd_ready_o <= 1'b1;
                state       <= S_IDLE;
              end else begin
                rsp_valid_o <= 1'b1;
                rsp_data_o  <= cap_q;
                state       <= S_RESP;
              end
            end else begin
              // Falling TCK edge: present the next TMS/TDI for the coming low phase
              case (state)
                S_PRE:
                  if (cnt != '0) begin
                    cnt     <= cnt - 6'd1;
                    tms_o   <= pre_tms[1];
                    pre_tms <= pre_tms >> 1;
                  end else begin
                    state <= S_SHIFT;
                    cnt   <= shift_len_m1;
                    tms_o <= (shift_len_m1 == '0);
                    tdi_o <= data_q[0];
                  end
                S_SHIFT: begin
                  bit_idx <= bit_idx + 6'd1;
                  data_q  <= data_q >> 1;
                  if (cnt != '0) begin
                    cnt   <= cnt - 6'd1;
                    tms_o <= (cnt == 6'd1);
                    tdi_o <= data_q[1];
                  end else begin
                    state <= S_POST;
                    cnt   <= 6'd1;
                    tms_o <= 1'b1;
                    tdi_o <= 1'b0;
                  end
                end
                default: begin
                  cnt   <= cnt - 6'd1;
                  tms_o <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_jtag_host.sv
// Bench for dmi_jtag_host: drives it against a behavioural TAP responder and
// checks TMS/TDI sequences, timing and captured data against a command-level model.
`timescale 1ns/1ps
module tb_dmi_jtag_host;

  localparam int          IR_LEN     = 5;
  localparam int          OP_RST     = 0;
  localparam int          OP_IR      = 1;
  localparam int          OP_DR      = 2;
  localparam int          OP_IDL     = 3;
  localparam logic [4:0]  IDCODE_IR  = 5'h01;
  localparam logic [31:0] IDCODE_VAL = 32'h0000_0001;

  logic        clk, rst_i;
  logic [7:0]  clk_div_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [5:0]  cmd_len_i;
  logic [63:0] cmd_data_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [63:0] rsp_data_o;
  logic        busy_o, tck_o, tms_o, tdi_o, trst_no, td_i;

  dmi_jtag_host #(.IrLength(IR_LEN), .ClkDivWidth(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .clk_div_i(clk_div_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_len_i(cmd_len_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o), .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o),
    .trst_no(trst_no), .td_i(td_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- TAP responder ----------------
  typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
                            SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR} tap_e;
  tap_e        tap_st;
  logic [4:0]  tap_ir, ir_sh;
  logic [31:0] dr;
  logic        byp, tdo;
  assign td_i = tdo;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PAU_DR;
      PAU_DR:  return m ? EX2_DR : PAU_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PAU_IR;
      PAU_IR:  return m ? EX2_IR : PAU_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck_o or negedge trst_no) begin
    if (!trst_no) begin
      tap_st <= TLR;
      tap_ir <= IDCODE_IR;
    end else begin
      case (tap_st)
        TLR:    tap_ir <= IDCODE_IR;
        CAP_IR: ir_sh  <= 5'h05;
        SH_IR:  ir_sh  <= {tdi_o, ir_sh[4:1]};
        UPD_IR: tap_ir <= ir_sh;
        CAP_DR: if (tap_ir == IDCODE_IR) dr <= IDCODE_VAL; else byp <= 1'b0;
        SH_DR:  if (tap_ir == IDCODE_IR) dr <= {tdi_o, dr[31:1]}; else byp <= tdi_o;
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms_o);
    end
  end

  always @(negedge tck_o or negedge trst_no) begin
    if (!trst_no) tdo <= 1'b0;
    else if (tap_st == SH_IR) tdo <= ir_sh[0];
    else if (tap_st == SH_DR) tdo <= (tap_ir == IDCODE_IR) ? dr[0] : byp;
    else tdo <= 1'b0;
  end

  // ---------------- command-level reference model ----------------
  logic [4:0] model_ir;
  logic exp_tms[$], exp_tdi[$], obs_tms[$], obs_tdi[$];
  int   cur_div;

  function automatic int n_bits(input logic [5:0] len);
    return (len == 6'd0) ? 64 : int'(len);
  endfunction

  function automatic int tck_count(input int op, input logic [5:0] len);
    case (op)
      OP_RST:  return 6;
      OP_IR:   return IR_LEN + 6;
      OP_DR:   return n_bits(len) + 5;
      default: return n_bits(len);
    endcase
  endfunction

  function automatic logic [63:0] model_rsp(input int op, input logic [5:0] len,
                                            input logic [63:0] data, input logic [4:0] ir);
    logic [63:0] r = '0;
    logic [31:0] cv;
    int n, w;
    if (op == OP_IR) return 64'h5;
    if (op != OP_DR) return '0;
    n  = n_bits(len);
    w  = (ir == IDCODE_IR) ? 32 : 1;
    cv = (ir == IDCODE_IR) ? IDCODE_VAL : 32'h0;
    for (int k = 0; k < n; k++) r[k] = (k < w) ? cv[k] : data[k - w];
    return r;
  endfunction

  task automatic push_exp(input logic m, input logic d);
    exp_tms.push_back(m);
    exp_tdi.push_back(d);
  endtask

  task automatic build_exp(input int op, input logic [5:0] len, input logic [63:0] data);
    int n;
    exp_tms.delete();
    exp_tdi.delete();
    n = (op == OP_IR) ? IR_LEN : n_bits(len);
    case (op)
      OP_RST: for (int k = 0; k < 6; k++) push_exp(k < 5, 1'b0);
      OP_IDL: for (int k = 0; k < n; k++) push_exp(1'b0, 1'b0);
      default: begin
        push_exp(1'b1, 1'b0);
        if (op == OP_IR) push_exp(1'b1, 1'b0);
        push_exp(1'b0, 1'b0);
        push_exp(1'b0, 1'b0);
        for (int k = 0; k < n; k++) push_exp(k == n - 1, data[k]);
        push_exp(1'b1, 1'b0);
        push_exp(1'b0, 1'b0);
      end
    endcase
  endtask

  task automatic check_seq();
    logic [127:0] a_m = '0, e_m = '0, a_d = '0, e_d = '0;
    for (int i = 0; i < obs_tms.size() && i < 128; i++) begin a_m[i] = obs_tms[i]; a_d[i] = obs_tdi[i]; end
    for (int i = 0; i < exp_tms.size() && i < 128; i++) begin e_m[i] = exp_tms[i]; e_d[i] = exp_tdi[i]; end
    check("tck_count", 128'(obs_tms.size()), 128'(exp_tms.size()));
    check("tms_seq", a_m, e_m);
    check("tdi_seq", a_d, e_d);
  endtask

  // ---------------- TCK monitor ----------------
  logic tck_prev = 1'b0;
  int   hi_run = 0;
  always @(negedge clk) begin
    if (tck_o === 1'b1 && tck_prev !== 1'b1) begin
      obs_tms.push_back(tms_o);
      obs_tdi.push_back(tdi_o);
      hi_run = 1;
    end else if (tck_o === 1'b1) begin
      hi_run++;
    end else if (tck_prev === 1'b1 && rst_i === 1'b0) begin
      check("tck_high_len", 128'(hi_run), 128'(cur_div + 1));
    end
    tck_prev = tck_o;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    int   k;
    logic saw_rsp;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    @(posedge clk); #1;
    check("reset_outs", 128'({tck_o, tms_o, tdi_o, trst_no, cmd_ready_o, rsp_valid_o, busy_o}), 128'(7'b0100001));
    check("reset_rsp_data", 128'(rsp_data_o), 128'(0));
    @(posedge clk); #1;
    clk_div_i = 8'd0;
    cur_div   = 0;
    model_ir  = IDCODE_IR;
    obs_tms.delete();
    obs_tdi.delete();
    build_exp(OP_RST, 6'd0, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("trst_held", 128'(trst_no), 128'(0));
    @(posedge clk); #1;
    check("trst_rise", 128'(trst_no), 128'(1));
    k = 0;
    saw_rsp = 1'b0;
    while (!cmd_ready_o && k < 1000) begin
      @(posedge clk); #1;
      k++;
      saw_rsp |= rsp_valid_o;
    end
    check("boot_latency", 128'(k), 128'(2 * tck_count(OP_RST, 6'd0)));
    check("boot_no_rsp", 128'(saw_rsp), 128'(0));
    check_seq();
    check("boot_tap", 128'({tap_st, tap_ir}), 128'({RTI, IDCODE_IR}));
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready_o && t < 500) begin @(posedge clk); #1; t++; end
    check("cmd_ready_wait", 128'(cmd_ready_o), 128'(1));
  endtask

  task automatic run_cmd(input int op, input logic [5:0] len, input logic [63:0] data,
                         input int div, input int hold, input logic [63:0] exp_rsp, input int exp_tcks);
    int   k;
    logic ok;
    wait_ready();
    build_exp(op, len, data);
    obs_tms.delete();
    obs_tdi.delete();
    cur_div     = div;
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'(op);
    cmd_len_i   = len;
    cmd_data_i  = data;
    clk_div_i   = 8'(div);
    @(posedge clk); #1;
    check("busy_after_accept", 128'({busy_o, cmd_ready_o}), 128'(2'b10));
    // junk command and divider while busy must have no effect
    cmd_op_i   = 2'($urandom);
    cmd_len_i  = 6'($urandom);
    cmd_data_i = {$urandom, $urandom};
    clk_div_i  = 8'($urandom);
    k = 0;
    while (!rsp_valid_o && k < 2000) begin @(posedge clk); #1; k++; end
    cmd_valid_i = 1'b0;
    check("rsp_latency", 128'(k), 128'(exp_tcks * 2 * (div + 1)));
    check("rsp_data", 128'(rsp_data_o), 128'(exp_rsp));
    check_seq();
    ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      ok &= rsp_valid_o && (rsp_data_o == exp_rsp) && !cmd_ready_o;
    end
    if (hold > 0) check("rsp_hold_stable", 128'(ok), 128'(1));
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    check("rsp_ack", 128'({rsp_valid_o, cmd_ready_o}), 128'(2'b01));
    if (op == OP_IR) model_ir = data[4:0];
    if (op == OP_RST) model_ir = IDCODE_IR;
    check("tap_after_cmd", 128'({tap_st, tap_ir}), 128'({RTI, model_ir}));
    if (hold > 0) begin
      ok = 1'b1;
      for (int h = 0; h < 4; h++) begin
        @(posedge clk); #1;
        ok &= !tck_o && cmd_ready_o && !rsp_valid_o && !busy_o;
      end
      check("no_latched_cmd", 128'(ok), 128'(1));
    end
  endtask

  typedef struct {
    int          op;
    logic [5:0]  len;
    logic [63:0] data;
    int          div;
    int          hold;
    logic [63:0] rsp;
    int          tcks;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{OP_IR,  6'd0,  64'h1,                    0, 0,  64'h5,                    11};
    tbl[1]  = '{OP_DR,  6'd32, 64'h0,                    0, 0,  64'h1,                    37};
    tbl[2]  = '{OP_DR,  6'd0,  64'h0123_4567_89AB_CDEF,  0, 0,  64'h89AB_CDEF_0000_0001,  69};
    tbl[3]  = '{OP_IR,  6'd0,  64'h1F,                   1, 0,  64'h5,                    11};
    tbl[4]  = '{OP_DR,  6'd8,  64'hA5,                   0, 0,  64'h4A,                   13};
    tbl[5]  = '{OP_DR,  6'd8,  64'h3C,                   3, 20, 64'h78,                   13};
    tbl[6]  = '{OP_IDL, 6'd4,  64'hFFFF,                 0, 0,  64'h0,                    4};
    tbl[7]  = '{OP_IDL, 6'd0,  64'h0,                    1, 0,  64'h0,                    64};
    tbl[8]  = '{OP_RST, 6'd17, 64'hFF,                   0, 0,  64'h0,                    6};
    tbl[9]  = '{OP_DR,  6'd1,  64'h1,                    0, 0,  64'h1,                    6};
    tbl[10] = '{OP_DR,  6'd33, 64'h1,                    2, 0,  64'h1_0000_0001,          38};
    tbl[11] = '{OP_IR,  6'd0,  64'hFFFF_FFF0,            0, 0,  64'h5,                    11};
    tbl[12] = '{OP_DR,  6'd2,  64'h3,                    0, 0,  64'h2,                    7};

    rst_i = 1'b1; clk_div_i = '0; cmd_valid_i = 1'b0; cmd_op_i = '0;
    cmd_len_i = '0; cmd_data_i = '0; rsp_ready_i = 1'b0; cur_div = 0;
    model_ir = IDCODE_IR;

    do_reset();

    for (int i = 0; i < 13; i++)
      run_cmd(tbl[i].op, tbl[i].len, tbl[i].data, tbl[i].div, tbl[i].hold, tbl[i].rsp, tbl[i].tcks);

    for (int i = 0; i < 30; i++) begin
      int          op, div;
      logic [5:0]  len;
      logic [63:0] data;
      op   = int'($urandom_range(0, 3));
      len  = 6'($urandom);
      data = {$urandom, $urandom};
      div  = int'($urandom_range(0, 2));
      run_cmd(op, len, data, div, 0, model_rsp(op, len, data, model_ir), tck_count(op, len));
    end

    // reset in the middle of a DR shift aborts and reruns the boot sequence
    wait_ready();
    cur_div     = 1;
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'(OP_DR);
    cmd_len_i   = 6'd40;
    cmd_data_i  = {$urandom, $urandom};
    clk_div_i   = 8'd1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_in_shift", 128'(tap_st), 128'(SH_DR));
    do_reset();

    run_cmd(OP_DR, 6'd32, 64'h0, 0, 0, model_rsp(OP_DR, 6'd32, 64'h0, model_ir), tck_count(OP_DR, 6'd32));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
